// File: rtl/hex_disp_ctrl.sv
// Multi-source 7-segment display controller with per-digit blink and rotating scroll.
// hex_out and blink_phase are fully registered; a sel change restarts scroll and blink timing.
module hex_disp_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter int unsigned SCROLL_DIV = 12500000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_SRC*NUM_DIGITS*8-1:0] src_bus,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          scroll_en,
  output logic [NUM_DIGITS*8-1:0]       hex_out,
  output logic                          blink_phase
);

  localparam int unsigned HEX_W    = NUM_DIGITS * 8;
  localparam int unsigned BLINK_W  = $clog2(BLINK_DIV);
  localparam int unsigned SCROLL_W = $clog2(SCROLL_DIV);
  localparam int unsigned OFF_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SEL_W-1:0]    sel_q;
  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [HEX_W-1:0]    hex_q, hex_d;
  logic                sel_chg;
  logic                sel_valid;

  assign sel_chg   = (sel != sel_q);
  assign sel_valid = (32'(sel) < NUM_SRC);

  // Scroll timing: held at zero when disabled, restarted by a source change.
  always_comb begin
    scroll_cnt_d = '0;
    offset_d     = '0;
    if (!sel_chg && scroll_en) begin
      if (scroll_cnt_q == SCROLL_W'(SCROLL_DIV - 1)) begin
        scroll_cnt_d = '0;
        offset_d     = (offset_q == OFF_W'(NUM_DIGITS - 1)) ? '0 : offset_q + OFF_W'(1);
      end else begin
        scroll_cnt_d = scroll_cnt_q + SCROLL_W'(1);
        offset_d     = offset_q;
      end
    end
  end

  // Blink timing: free-running, restarted visible by a source change.
  always_comb begin
    blink_cnt_d   = '0;
    blink_phase_d = 1'b1;
    if (!sel_chg) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
      end
    end
  end

  // Display image uses next-state offset/phase so it lines up with blink_phase.
  always_comb begin : p_image
    int unsigned idx;
    logic [7:0]  digit;
    idx   = 0;
    digit = 8'hFF;
    hex_d = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      idx = d + 32'(offset_d);
      if (idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
      digit = 8'hFF;
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (32'(sel) == s) digit = src_bus[(s*NUM_DIGITS + idx)*8 +: 8];
      end
      if (blink_mask[d] && !blink_phase_d) digit = 8'hFF;
      if (!sel_valid) digit = 8'h7F;
      hex_d[d*8 +: 8] = digit;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q         <= '0;
      scroll_cnt_q  <= '0;
      offset_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      hex_q         <= '1;
    end else begin
      sel_q         <= sel;
      scroll_cnt_q  <= scroll_cnt_d;
      offset_q      <= offset_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      hex_q         <= hex_d;
    end
  end

  assign hex_out     = hex_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Directed bench for hex_disp_ctrl: reset, latency, scroll, blink, sel-change restart,
// out-of-range source and asynchronous reset mid-scroll.
module tb_hex_disp_ctrl;

  logic         clk;
  logic         reset_n;
  logic [1:0]   sel;
  logic [191:0] src_bus;
  logic [5:0]   blink_mask;
  logic         scroll_en;
  logic [47:0]  hex_out, hex_out3;
  logic         blink_phase, blink_phase3;

  logic [47:0]  src [4];
  logic [47:0]  exp_hex;
  int           n_chk;
  int           n_err;

  hex_disp_ctrl #(
    .NUM_DIGITS(6), .NUM_SRC(4), .SEL_W(2), .BLINK_DIV(4), .SCROLL_DIV(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src_bus(src_bus),
    .blink_mask(blink_mask), .scroll_en(scroll_en),
    .hex_out(hex_out), .blink_phase(blink_phase)
  );

  hex_disp_ctrl #(
    .NUM_DIGITS(6), .NUM_SRC(3), .SEL_W(2), .BLINK_DIV(4), .SCROLL_DIV(3)
  ) dut3 (
    .clk(clk), .reset_n(reset_n), .sel(sel), .src_bus(src_bus[143:0]),
    .blink_mask(blink_mask), .scroll_en(scroll_en),
    .hex_out(hex_out3), .blink_phase(blink_phase3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] rot(input logic [47:0] v, input int off);
    logic [47:0] r;
    r = '0;
    for (int d = 0; d < 6; d++) r[d*8 +: 8] = v[((d + off) % 6)*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and check the asynchronous reset state while low.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_hex", hex_out, {48{1'b1}});
    chk("rst_phase", 48'(blink_phase), 48'd1);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    sel        = 2'd0;
    scroll_en  = 1'b0;
    blink_mask = 6'b0;
    src[0] = 48'h86_88_A1_91_AF_7F;
    src[1] = 48'h01_02_03_04_05_06;
    src[2] = 48'h10_20_30_40_50_60;
    src[3] = 48'hC0_C1_C2_C3_C4_C5;
    src_bus = {src[3], src[2], src[1], src[0]};

    // Reset release, first update one cycle later.
    apply_reset();
    step();
    chk("first_img", hex_out, 48'h86_88_A1_91_AF_7F);
    chk("first_phase", 48'(blink_phase), 48'd1);

    // One-cycle latency on sel and src_bus changes.
    sel = 2'd1;
    step();
    chk("sel_latency", hex_out, src[1]);
    src[1][7:0] = 8'h99;
    src_bus = {src[3], src[2], src[1], src[0]};
    step();
    chk("src_latency", hex_out, 48'h01_02_03_04_05_99);
    sel = 2'd0;

    // Blink on digit 0 only, 4-cycle half period.
    blink_mask = 6'b000001;
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_hex = src[0];
      if (((k / 4) % 2) != 0) exp_hex[7:0] = 8'hFF;
      chk("blink_hex", hex_out, exp_hex);
      chk("blink_phase", 48'(blink_phase), 48'(((k / 4) % 2) == 0));
    end

    // Scroll: one step every 3 cycles, full turn after 18.
    blink_mask = 6'b0;
    scroll_en  = 1'b1;
    apply_reset();
    for (int k = 1; k <= 18; k++) begin
      step();
      chk("scroll_img", hex_out, rot(src[0], (k / 3) % 6));
      if (k == 3) begin
        chk("scroll_d0", 48'(hex_out[7:0]), 48'hAF);
        chk("scroll_d5", 48'(hex_out[47:40]), 48'h7F);
      end
    end
    chk("scroll_wrap", hex_out, 48'h86_88_A1_91_AF_7F);

    // sel change coinciding with a scroll tick restarts scroll and blink.
    apply_reset();
    step();
    step();
    sel = 2'd2;
    step();
    chk("selchg_img", hex_out, src[2]);
    chk("selchg_phase", 48'(blink_phase), 48'd1);
    step();
    chk("selchg_e4_img", hex_out, src[2]);
    chk("selchg_e4_phase", 48'(blink_phase), 48'd1);
    step();
    chk("selchg_e5_img", hex_out, src[2]);
    step();
    chk("selchg_e6_img", hex_out, rot(src[2], 1));
    chk("selchg_e6_phase", 48'(blink_phase), 48'd1);
    step();
    chk("selchg_e7_phase", 48'(blink_phase), 48'd0);

    // Out-of-range source on the 3-source instance.
    sel        = 2'd3;
    blink_mask = 6'h3F;
    scroll_en  = 1'b1;
    apply_reset();
    step();
    chk("sel3_valid_img", hex_out, src[3]);
    chk("sel3_dp_img", hex_out3, 48'h7F_7F_7F_7F_7F_7F);
    for (int k = 2; k <= 10; k++) begin
      step();
      chk("sel3_dp_hold", hex_out3, 48'h7F_7F_7F_7F_7F_7F);
      if (k == 5) begin
        chk("sel3_dp_phase", 48'(blink_phase3), 48'd0);
        chk("sel3_valid_blank", hex_out, {48{1'b1}});
      end
    end

    // Asynchronous reset mid-scroll restarts the offset at 0.
    sel        = 2'd0;
    blink_mask = 6'b0;
    apply_reset();
    for (int k = 1; k <= 4; k++) step();
    chk("midscroll_img", hex_out, rot(src[0], 1));
    apply_reset();
    step();
    chk("post_rst_img", hex_out, src[0]);
    step();
    step();
    chk("post_rst_scroll", hex_out, rot(src[0], 1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hex_disp_ctrl.md
HEX_DISP_CTRL -- requirements
Module: hex_disp_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 6, SHALL set the number of 7-segment digits driven (digit 0 is rightmost).
REQ-002 Parameter NUM_SRC, default 4, SHALL set the number of selectable display sources.
REQ-003 Parameter SEL_W, default 2, SHALL set the width of sel and SHALL satisfy 2**SEL_W >= NUM_SRC.
REQ-004 Parameter BLINK_DIV, default 25000000, SHALL set the clock cycles per blink half-period (>= 2).
REQ-005 Parameter SCROLL_DIV, default 12500000, SHALL set the clock cycles per scroll step (>= 2).
REQ-006 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 sel  input  SEL_W  SHALL select the source; it is the game state code.
REQ-009 src_bus  input  NUM_SRC*NUM_DIGITS*8  SHALL carry segment patterns; source s digit d occupies bits [(s*NUM_DIGITS+d)*8 +: 8].
REQ-010 blink_mask  input  NUM_DIGITS  SHALL mark physical display positions that blink.
REQ-011 scroll_en  input  1  SHALL enable rotation of the selected source across the digits.
REQ-012 hex_out  output  NUM_DIGITS*8  SHALL drive the displays; digit d occupies bits [d*8 +: 8], active-low segments, bit 7 = decimal point.
REQ-013 blink_phase  output  1  SHALL expose the current blink phase (1 = visible).

Function
REQ-014 hex_out SHALL be registered; a change on sel, src_bus, blink_mask or scroll_en SHALL be reflected on hex_out exactly one cycle later.
REQ-015 Register sel_q SHALL hold sel from the previous cycle; a sel change is detected as sel != sel_q.
REQ-016 Scroll offset register SHALL range 0..NUM_DIGITS-1; digit d of hex_out SHALL show source digit (d + offset) mod NUM_DIGITS.
REQ-017 Scroll counter SHALL count 0..SCROLL_DIV-1 while scroll_en=1; on reaching SCROLL_DIV-1 it SHALL wrap to 0 and offset SHALL increment, wrapping NUM_DIGITS-1 -> 0.
REQ-018 When scroll_en=0, scroll counter and offset SHALL be held at 0.
REQ-019 Blink counter SHALL count 0..BLINK_DIV-1 continuously; on reaching BLINK_DIV-1 it SHALL wrap to 0 and blink_phase SHALL toggle.
REQ-020 Digit position d SHALL output 8'hFF (blank) when blink_mask[d]=1 and blink_phase=0; the mask applies after scrolling.
REQ-021 A sel change SHALL, in that cycle, clear scroll counter, offset and blink counter and set blink_phase=1; this overrides any simultaneous scroll or blink tick.
REQ-022 sel >= NUM_SRC SHALL drive every digit to 8'h7F (decimal point only), ignoring scroll and blink_mask; counters continue per REQ-017..REQ-019.
REQ-023 Counter widths SHALL be $clog2 of their modulus; no counter SHALL exceed its stated maximum.
REQ-024 No combinational path SHALL exist from any input to hex_out or blink_phase.

Reset
REQ-025 While reset_n=0, hex_out SHALL be all 8'hFF, blink_phase 1, sel_q 0, all counters and offset 0, independent of clk.
REQ-026 Reset asserted mid-scroll or mid-blink SHALL take effect immediately; after release the first update SHALL follow REQ-014 with offset 0.

Verification
REQ-027 Params NUM_DIGITS=6, NUM_SRC=4, BLINK_DIV=4, SCROLL_DIV=3; sel=0, src0 digits 5..0 = 8'h86,8'h88,8'hA1,8'h91,8'hAF,8'h7F, release reset -> one cycle later hex_out = {86,88,A1,91,AF,7F}.
REQ-028 Same, scroll_en=1 -> after 3 cycles digit 0 = 8'hAF, digit 5 = 8'h7F; after 18 cycles offset back to 0 and original pattern.
REQ-029 blink_mask=6'b000001, scroll_en=0 -> digit 0 alternates 8'h7F / 8'hFF every 4 cycles, blink_phase toggles in step, other digits steady.
REQ-030 sel 0->2 on the same cycle as a scroll tick -> next cycle hex_out = source 2 unrotated, blink_phase=1, blink counter 0.
REQ-031 NUM_SRC=3, sel=3 -> all digits 8'h7F regardless of blink_mask=6'h3F and scroll_en=1.
REQ-032 reset_n pulsed low between clk edges mid-scroll -> hex_out = all 8'hFF immediately; after release offset restarts from 0.
